// File: rtl/txn_dispatch_if.sv
// Command and engine handshake bundle for txn_dispatch_scheduler.
// master = host/engine side, slave = dispatcher.
interface txn_dispatch_if #(
  parameter int NUM_CH = 3,
  parameter int ID_W   = 4,
  parameter int CH_W   = 2
);
  localparam int NE = 2 * NUM_CH;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ID_W-1:0]   cmd_id;
  logic [CH_W-1:0]   cmd_ch;
  logic              cmd_wr;
  logic [NE-1:0]     eng_start;
  logic [NE*ID_W-1:0] eng_id;
  logic [NE-1:0]     eng_done;
  logic [NE-1:0]     eng_busy;

  modport master (
    output cmd_valid, cmd_id, cmd_ch, cmd_wr, eng_done,
    input  cmd_ready, eng_start, eng_id, eng_busy
  );

  modport slave (
    input  cmd_valid, cmd_id, cmd_ch, cmd_wr, eng_done,
    output cmd_ready, eng_start, eng_id, eng_busy
  );
endinterface

// File: rtl/txn_dispatch_scheduler.sv
// Age-ordered command queue feeding 2*NUM_CH engines (engine = 2*ch + wr).
// Entries move pending -> running -> retired; the valid/running bits are the
// whole per-entry state, so no explicit state machine is needed. An entry may
// only start once no older entry with the same ID remains in the queue.
module txn_dispatch_scheduler #(
  parameter int NUM_CH = 3,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 16,
  parameter int CH_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  txn_dispatch_if.slave            bus,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     err
);
  localparam int NE    = 2 * NUM_CH;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int EW    = CH_W + 1;

  logic [DEPTH-1:0] q_valid, q_run, q_wr;
  logic [ID_W-1:0]  q_id [DEPTH];
  logic [CH_W-1:0]  q_ch [DEPTH];
  logic [CNT_W-1:0] count;
  logic [NE-1:0]    busy_r, start_r;
  logic [NE*ID_W-1:0] eng_id_r;
  logic             err_r;

  logic             accept, ch_ok;
  logic [NE-1:0]    done_ok, done_bad, eng_win;
  logic [ID_W-1:0]  win_id [NE];
  logic [EW-1:0]    ent_eng [DEPTH];
  logic [DEPTH-1:0] ent_busy, ent_done, retire, id_blk, elig, win;

  logic [DEPTH-1:0] n_valid, n_run, n_wr;
  logic [ID_W-1:0]  n_id [DEPTH];
  logic [CH_W-1:0]  n_ch [DEPTH];
  logic [CNT_W-1:0] wp, n_count;

  assign bus.cmd_ready = (count < CNT_W'(DEPTH));
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign ch_ok         = ({1'b0, bus.cmd_ch} < EW'(NUM_CH));
  assign done_ok       = bus.eng_done & busy_r;
  assign done_bad      = bus.eng_done & ~busy_r;
  assign bus.eng_start = start_r;
  assign bus.eng_busy  = busy_r;
  assign bus.eng_id    = eng_id_r;
  assign q_count       = count;
  assign err           = err_r;

  // Map each entry to its engine and find which running entries retire now.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_eng[i]  = {q_ch[i], q_wr[i]};
      ent_busy[i] = 1'b0;
      ent_done[i] = 1'b0;
      for (int e = 0; e < NE; e++) begin
        if (ent_eng[i] == EW'(e)) begin
          ent_busy[i] = busy_r[e];
          ent_done[i] = done_ok[e];
        end
      end
      retire[i] = q_valid[i] & q_run[i] & ent_done[i];
    end
  end

  // Pending entry is eligible when its engine is idle and no older entry shares its ID.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      id_blk[i] = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (j < i && q_valid[j] && q_id[j] == q_id[i]) id_blk[i] = 1'b1;
      end
      elig[i] = q_valid[i] & ~q_run[i] & ~ent_busy[i] & ~id_blk[i];
    end
  end

  // Oldest eligible entry per engine wins.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      win[i] = elig[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j < i && elig[j] && ent_eng[j] == ent_eng[i]) win[i] = 1'b0;
      end
    end
  end

  // Collapse per-entry winners into per-engine start requests.
  always_comb begin
    eng_win = '0;
    for (int e = 0; e < NE; e++) win_id[e] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int e = 0; e < NE; e++) begin
        if (win[i] && ent_eng[i] == EW'(e)) begin
          eng_win[e] = 1'b1;
          win_id[e]  = q_id[i];
        end
      end
    end
  end

  // Next queue image: drop retirees, compact survivors in age order, then append.
  always_comb begin
    n_valid = '0;
    n_run   = '0;
    n_wr    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n_id[i] = '0;
      n_ch[i] = '0;
    end
    wp = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid[i] && !retire[i]) begin
        n_valid[wp[IDX_W-1:0]] = 1'b1;
        n_run[wp[IDX_W-1:0]]   = q_run[i] | win[i];
        n_id[wp[IDX_W-1:0]]    = q_id[i];
        n_ch[wp[IDX_W-1:0]]    = q_ch[i];
        n_wr[wp[IDX_W-1:0]]    = q_wr[i];
        wp = wp + CNT_W'(1);
      end
    end
    n_count = wp;
    if (accept && ch_ok) begin
      n_valid[wp[IDX_W-1:0]] = 1'b1;
      n_id[wp[IDX_W-1:0]]    = bus.cmd_id;
      n_ch[wp[IDX_W-1:0]]    = bus.cmd_ch;
      n_wr[wp[IDX_W-1:0]]    = bus.cmd_wr;
      n_count = wp + CNT_W'(1);
    end
  end

  // Register queue, engine status and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid  <= '0;
      q_run    <= '0;
      q_wr     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_id[i] <= '0;
        q_ch[i] <= '0;
      end
      count    <= '0;
      busy_r   <= '0;
      start_r  <= '0;
      eng_id_r <= '0;
      err_r    <= 1'b0;
    end else begin
      q_valid <= n_valid;
      q_run   <= n_run;
      q_wr    <= n_wr;
      q_id    <= n_id;
      q_ch    <= n_ch;
      count   <= n_count;
      start_r <= eng_win;
      busy_r  <= (busy_r & ~done_ok) | eng_win;
      for (int e = 0; e < NE; e++) begin
        if (eng_win[e]) eng_id_r[e*ID_W +: ID_W] <= win_id[e];
      end
      err_r <= err_r | (|done_bad) | (accept & ~ch_ok);
    end
  end
endmodule
